program_loader: RTL and testbench

//  Writer side of the instruction memory: collects a program from the UART

---
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Purpose: bundles the program_loader control, UART byte stream and
//          instruction-memory write port into one interface.
// Ports:   i_start/i_rx_data/i_rx_valid in to the loader (slave side);
//          o_we/o_addr/o_wdata/o_busy/o_done/o_overflow/o_count out of it.
interface program_loader_if #(
  parameter int ADDR_W = 6
);
  logic              i_start;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [31:0]       o_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_overflow;
  logic [ADDR_W:0]   o_count;

  // Debug unit / UART / memory side.
  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_we, o_addr, o_wdata, o_busy, o_done, o_overflow, o_count
  );

  // Loader side.
  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_we, o_addr, o_wdata, o_busy, o_done, o_overflow, o_count
  );
endinterface

// File: rtl/program_loader.sv
// Purpose: packs UART bytes big-endian into 32-bit words and writes them to
//          consecutive instruction-memory addresses until HALT or memory full.
// Ports:   clk, reset (sync, active-high), bus (program_loader_if.slave).
//          Write latency: o_we one cycle after the 4th byte strobe; never stalls.
module program_loader #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_shift;     // only the three oldest bytes are ever needed
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_overflow;
  logic [ADDR_W:0]   r_count;

  logic              w_byte_acc;
  logic              w_word_done;
  logic              w_is_halt;
  logic              w_is_last;
  logic              w_enter_load;

  assign w_byte_acc   = (r_state == S_LOAD) && bus.i_rx_valid;
  assign w_word_done  = w_byte_acc && (r_byte_cnt == 2'd3);
  // Both terminations are judged on the word being written this cycle.
  assign w_is_halt    = r_we && (r_wdata == HALT_WORD);
  assign w_is_last    = r_we && (r_addr == {ADDR_W{1'b1}});
  assign w_enter_load = (r_state != S_LOAD) && (w_state_nxt == S_LOAD);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.i_start)             w_state_nxt = S_LOAD;
      S_LOAD: if (w_is_halt || w_is_last)  w_state_nxt = S_DONE;
      S_DONE: if (bus.i_start)             w_state_nxt = S_LOAD;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      r_we <= w_word_done;
      if (w_enter_load) begin
        r_byte_cnt <= 2'd0;
        r_addr     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        // A byte in the write cycle is independent of the address bump below.
        if (w_byte_acc) begin
          r_shift    <= {r_shift[15:0], bus.i_rx_data};
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_wdata <= {r_shift, bus.i_rx_data};
          end
        end
        if (r_we) begin
          // Address wraps to 0 naturally after the last slot.
          r_addr  <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
          if (w_is_last && !w_is_halt) begin
            r_overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_we       = r_we;
  assign bus.o_addr     = r_addr;
  assign bus.o_wdata    = r_wdata;
  assign bus.o_busy     = (r_state == S_LOAD);
  assign bus.o_done     = (r_state == S_DONE);
  assign bus.o_overflow = r_overflow;
  assign bus.o_count    = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Purpose: self-checking bench for program_loader: vector table, directed
//          corner sequences and randomized traffic against a byte-queue model.
// Ports:   none (top-level bench).
module tb_program_loader;

  localparam int          ADDR_W = 6;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] HALT   = 32'hFFFFFFFF;

  logic clk;
  logic reset;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_we_seen = 0;

  // Reference model: mode 0=idle 1=load 2=done; bytes of the word in progress
  // are kept in a queue, words written are simply counted.
  int          m_mode;
  logic [7:0]  m_bytes[$];
  int          m_words;
  bit          m_we;
  logic [31:0] m_wdata;
  bit          m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the same edge and
  // compare every output shortly after the edge.
  task automatic apply(input bit rst, input bit st, input bit vld, input logic [7:0] d);
    bit new_we;
    reset          = rst;
    bus.i_start    = st;
    bus.i_rx_valid = vld;
    bus.i_rx_data  = d;
    @(posedge clk);
    #1;
    new_we = 1'b0;
    if (rst) begin
      m_mode  = 0;
      m_bytes.delete();
      m_words = 0;
      m_wdata = 32'd0;
      m_ovf   = 1'b0;
    end else if (m_mode == 1) begin
      if (m_we) begin
        m_words++;
        if (m_wdata == HALT) begin
          m_mode = 2;
        end else if (m_words == DEPTH) begin
          m_mode = 2;
          m_ovf  = 1'b1;
        end
      end
      if (vld) begin
        m_bytes.push_back(d);
        if (m_bytes.size() == 4) begin
          m_wdata = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          new_we  = 1'b1;
          m_bytes.delete();
        end
      end
    end else if (st) begin
      m_mode  = 1;
      m_bytes.delete();
      m_words = 0;
      m_ovf   = 1'b0;
    end
    m_we = new_we;

    if (bus.o_we === 1'b1) n_we_seen++;
    chk("we",       bus.o_we,       m_we);
    chk("addr",     bus.o_addr,     m_words % DEPTH);
    chk("wdata",    bus.o_wdata,    m_wdata);
    chk("count",    bus.o_count,    m_words);
    chk("busy",     bus.o_busy,     m_mode == 1);
    chk("done",     bus.o_done,     m_mode == 2);
    chk("overflow", bus.o_overflow, m_ovf);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) apply(1'b0, 1'b0, 1'b1, w[k*8 +: 8]);
  endtask

  typedef struct {
    bit          st;
    bit          vld;
    logic [7:0]  d;
    bit          we;
    int          addr;
    logic [31:0] wdata;
    int          count;
    bit          busy;
    bit          done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] w;

    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data = 8'h00;
    m_mode = 0; m_words = 0; m_we = 0; m_wdata = 0; m_ovf = 0;

    // 1: reset, then idle with byte strobes: nothing may be written
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    n_we_seen = 0;
    for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 1'b1, 8'(i * 17 + 3));
    chk("idle_no_we", n_we_seen, 0);

    // 2: table-driven single word 12 34 56 78
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 32'h0,        0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h12, 1'b0, 0, 32'h0,        0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h34, 1'b0, 0, 32'h0,        0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h56, 1'b0, 0, 32'h0,        0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h78, 1'b1, 0, 32'h12345678, 0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 32'h12345678, 1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 32'h12345678, 1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, vecs[i].st, vecs[i].vld, vecs[i].d);
      chk("tbl_we",    bus.o_we,    vecs[i].we);
      chk("tbl_addr",  bus.o_addr,  vecs[i].addr);
      chk("tbl_wdata", bus.o_wdata, vecs[i].wdata);
      chk("tbl_count", bus.o_count, vecs[i].count);
      chk("tbl_busy",  bus.o_busy,  vecs[i].busy);
      chk("tbl_done",  bus.o_done,  vecs[i].done);
    end

    // 3: word then HALT, trailing bytes ignored
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    n_we_seen = 0;
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    send_word(32'h20010005);
    send_word(HALT);
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b0, 1'b1, 8'h5A);
    chk("halt_we_count", n_we_seen, 2);
    chk("halt_done",     bus.o_done, 1);
    chk("halt_ovf",      bus.o_overflow, 0);
    chk("halt_count",    bus.o_count, 2);
    chk("halt_wdata",    bus.o_wdata, HALT);

    // 4: fill memory with non-HALT words (restart from DONE)
    n_we_seen = 0;
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      if (w == HALT) w = 32'h0;
      send_word(w);
      apply(1'b0, 1'b0, 1'b0, 8'h00);
    end
    apply(1'b0, 1'b0, 1'b1, 8'h11);
    chk("full_we_count", n_we_seen, DEPTH);
    chk("full_done",     bus.o_done, 1);
    chk("full_ovf",      bus.o_overflow, 1);
    chk("full_count",    bus.o_count, DEPTH);
    chk("full_addr",     bus.o_addr, 0);

    // 5: reset mid-word discards stale bytes
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    apply(1'b0, 1'b0, 1'b1, 8'h01);
    apply(1'b0, 1'b0, 1'b1, 8'h02);
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    n_we_seen = 0;
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    send_word(32'hAABBCCDD);
    chk("rst_we",    bus.o_we, 1);
    chk("rst_addr",  bus.o_addr, 0);
    chk("rst_wdata", bus.o_wdata, 32'hAABBCCDD);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_we_count", n_we_seen, 1);

    // 6: back-to-back bytes, including the write cycle, with start pulses
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    n_we_seen = 0;
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) apply(1'b0, (i % 7) == 3, 1'b1, 8'(i * 13 + 1));
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk("b2b_we_count", n_we_seen, 10);
    chk("b2b_count",    bus.o_count, 10);
    chk("b2b_wdata",    bus.o_wdata, {8'(36*13+1), 8'(37*13+1), 8'(38*13+1), 8'(39*13+1)});

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      bit rr, ss, vv;
      logic [7:0] dd;
      rr = ($urandom_range(999) == 0);
      ss = ($urandom_range(29) == 0);
      vv = ($urandom_range(2) != 0);
      dd = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom());
      apply(rr, ss, vv, dd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
